// File: rtl/bcd_convert_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding and the
// constants used by the shift-and-add-3 digit correction.
package bcd_convert_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_convert_if.sv
// Request/result bundle between the calculator datapath (master) and the
// converter (slave).
interface bcd_convert_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);

    logic                  start;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  rdy;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output count,
        input  busy,
        input  rdy,
        input  bcd
    );

    modport slave (
        input  start,
        input  count,
        output busy,
        output rdy,
        output bcd
    );

endinterface

// File: rtl/bcd_convert_digit_adj.sv
// Single-digit correction ahead of the shift: any digit of 5 or more gets 3
// added so that doubling it carries correctly into the next decade.
module bcd_digit_adj
    import bcd_convert_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    // Conditional add-3 on one BCD digit.
    assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d + DIGIT_W'(ADJ_ADD) : d;

endmodule

// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter ("double dabble"). A start pulse in IDLE
// captures the operand; WIDTH adjust-and-shift cycles follow, then the packed
// BCD result is latched into the output register with a one-cycle rdy pulse.
module bcd_convert
    import bcd_convert_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
)(
    input  logic          clk,
    input  logic          rst,
    bcd_convert_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [SR_W-1:0]    sr;        // {BCD scratch, remaining binary bits}
    logic [CNT_W-1:0]   bit_cnt;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               rdy_q;

    logic [BCD_W-1:0]   scratch_adj;
    logic [SR_W-1:0]    sr_pre;
    logic [SR_W-1:0]    sr_next;

    // One correction cell per decade of the scratch area.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (sr[WIDTH + g*DIGIT_W +: DIGIT_W]),
            .q (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Adjusted digits rejoin the binary tail, then the whole word moves left.
    assign sr_pre  = {scratch_adj, sr[WIDTH-1:0]};
    assign sr_next = sr_pre << 1;

    // FSM, shift register, bit counter and result register. busy follows the
    // state one edge late, so it drops the cycle after the rdy pulse.
    // NOTE: every register here uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            busy_q <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr      <= {{BCD_W{1'b0}}, bus.count};
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= sr_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_q <= sr[SR_W-1:WIDTH];
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.rdy  = rdy_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert.sv
// Self-checking bench for bcd_convert: directed corner cases plus a full
// 0..4095 sweep, with results matched against a decimal reference model
// through an expectation queue.
module tb_bcd_convert;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH + 1;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        int                  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    bcd_convert_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_convert #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Decimal reference: peel off base-10 digits arithmetically.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start sampled on the next edge; optionally register the expectation.
    task automatic drive_start(input int v, input bit expect_result);
        exp_t e;
        bus.start = 1'b1;
        bus.count = WIDTH'(v);
        if (expect_result) begin
            e.bcd = to_bcd(v);
            e.cyc = cyc + 1 + LAT;
            sb.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    // Full conversion; returns 1ns after the edge that raises rdy.
    task automatic run_one(input int v);
        drive_start(v, 1'b1);
        repeat (LAT) tick();
    endtask

    // Result monitor: every rdy must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (!rst && bus.rdy) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_bcd", 32'(bus.bcd), 32'(e.bcd));
                check("sb_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.count = '0;

        // Reset state.
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdy",  32'(bus.rdy),  32'd0);
        check("rst_bcd",  32'(bus.bcd),  32'd0);
        rst = 1'b0;
        tick();

        // Zero operand: rdy on time, busy falls one cycle after rdy.
        drive_start(0, 1'b1);
        tick();
        check("busy_rise", 32'(bus.busy), 32'd1);
        repeat (LAT - 1) tick();
        check("zero_rdy",  32'(bus.rdy),  32'd1);
        check("zero_bcd",  32'(bus.bcd),  32'h0000);
        check("zero_busy_at_rdy", 32'(bus.busy), 32'd1);
        tick();
        check("zero_busy_fall", 32'(bus.busy), 32'd0);
        check("zero_rdy_pulse", 32'(bus.rdy),  32'd0);
        check("zero_bcd_hold",  32'(bus.bcd),  32'h0000);

        // Representative values.
        run_one(4095);
        check("bcd_4095", 32'(bus.bcd), 32'h4095);
        run_one(255);
        check("bcd_255", 32'(bus.bcd), 32'h0255);
        run_one(10);
        check("bcd_10", 32'(bus.bcd), 32'h0010);
        tick();

        // Start re-asserted while busy is ignored.
        drive_start(123, 1'b1);
        repeat (2) tick();
        drive_start(999, 1'b0);
        repeat (9) tick();
        drive_start(999, 1'b0);
        check("ignore_rdy", 32'(bus.rdy), 32'd1);
        check("ignore_bcd", 32'(bus.bcd), 32'h0123);
        repeat (3) tick();
        check("ignore_busy", 32'(bus.busy), 32'd0);
        check("ignore_hold", 32'(bus.bcd),  32'h0123);

        // Reset mid-conversion aborts without rdy and clears bcd.
        drive_start(500, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd",  32'(bus.bcd),  32'h0000);
        check("abort_rdy",  32'(bus.rdy),  32'd0);
        repeat (16) tick();
        check("abort_idle", 32'(bus.busy), 32'd0);
        run_one(42);
        check("bcd_42", 32'(bus.bcd), 32'h0042);
        tick();

        // Operand changes after acceptance have no effect.
        drive_start(77, 1'b1);
        for (int i = 0; i < LAT - 1; i++) begin
            bus.count = WIDTH'($urandom);
            tick();
        end
        tick();
        check("bcd_77", 32'(bus.bcd), 32'h0077);
        tick();

        // Reset wins over a simultaneous start.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.count = WIDTH'(5);
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        // Exhaustive sweep at minimum start spacing.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            run_one(v);
        end
        repeat (4) tick();
        check("drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
